lenet_feeder: RTL

LENET_FEEDER -- requirements
Module: lenet_feeder

---
 rtl/lenet_feeder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lenet_feeder.sv
// Crops a window of the frame buffer, box-averages BLKxBLK blocks into an
// OUTDIMxOUTDIM image for the LeNet input memory, then runs one inference.
module lenet_feeder #(
  parameter int WIDTH  = 640,
  parameter int X0     = 96,
  parameter int Y0     = 16,
  parameter int BLK    = 16,
  parameter int OUTDIM = 28,
  parameter int INVERT = 1
) (
  input  logic        clk25,
  input  logic        rst_n,
  input  logic        lenet_signal,
  output logic [18:0] addr_mem0,
  input  logic [7:0]  din,
  output logic [9:0]  addr_mem2,
  output logic [7:0]  data_mem2,
  output logic        we_mem2,
  output logic        lenet_go,
  input  logic        lenet_ready,
  input  logic [3:0]  lenet_digit,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        busy
);
  localparam int KW = $clog2(BLK*BLK);
  localparam int SH = $clog2(BLK);
  localparam int OW = $clog2(OUTDIM);
  localparam logic [KW-1:0] K_LAST = KW'(BLK*BLK-1);
  localparam logic [KW-1:0] K_MASK = KW'(BLK-1);
  localparam logic [OW-1:0] O_LAST = OW'(OUTDIM-1);

  typedef enum logic [2:0] {IDLE, ACCUM, LAST, WRITE, GO, WAIT} state_t;

  state_t        state_q, state_d;
  logic          meta_q, sync_q, sync_prev_q;
  logic [OW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [KW-1:0] k_q, k_d;
  logic [15:0]   sum_q, sum_d;
  logic [18:0]   addr_mem0_q, addr_mem0_d;
  logic [9:0]    addr_mem2_q, addr_mem2_d;
  logic [7:0]    data_mem2_q, data_mem2_d, avg;
  logic          we_mem2_q, lenet_go_q, busy_q;
  logic [3:0]    digit_q, digit_d;
  logic          digit_valid_q, digit_valid_d;
  logic [31:0]   row, col;
  logic          start;

  assign start = sync_q & ~sync_prev_q;

  always_comb begin
    state_d       = state_q;
    ox_d          = ox_q;
    oy_d          = oy_q;
    k_d           = k_q;
    sum_d         = sum_q;
    digit_d       = digit_q;
    digit_valid_d = digit_valid_q;
    case (state_q)
      IDLE: if (start) begin
        state_d       = ACCUM;
        ox_d          = '0;
        oy_d          = '0;
        k_d           = '0;
        sum_d         = '0;
        digit_valid_d = 1'b0;
      end
      // din lags the address by one cycle, so the first ACCUM cycle has nothing to add
      ACCUM: begin
        if (k_q != '0) sum_d = sum_q + 16'(din);
        if (k_q == K_LAST) state_d = LAST;
        else               k_d = k_q + 1'b1;
      end
      LAST: begin
        sum_d   = sum_q + 16'(din);
        state_d = WRITE;
      end
      WRITE: begin
        sum_d   = '0;
        k_d     = '0;
        state_d = ACCUM;
        if (ox_q == O_LAST) begin
          ox_d = '0;
          if (oy_q == O_LAST) begin
            oy_d    = '0;
            state_d = GO;
          end else begin
            oy_d = oy_q + 1'b1;
          end
        end else begin
          ox_d = ox_q + 1'b1;
        end
      end
      GO:   state_d = WAIT;
      WAIT: if (lenet_ready) begin
        digit_d       = lenet_digit;
        digit_valid_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are computed from the next-cycle state.
    row = 32'(Y0) + 32'(oy_d) * 32'(BLK) + 32'(k_d >> SH);
    col = 32'(X0) + 32'(ox_d) * 32'(BLK) + 32'(k_d & K_MASK);
    addr_mem0_d = (state_d == ACCUM) ? 19'(row * 32'(WIDTH) + col) : addr_mem0_q;

    avg         = 8'(sum_d >> KW);
    addr_mem2_d = addr_mem2_q;
    data_mem2_d = data_mem2_q;
    if (state_d == WRITE) begin
      addr_mem2_d = 10'(32'(oy_q) * 32'(OUTDIM) + 32'(ox_q));
      data_mem2_d = (INVERT != 0) ? 8'd255 - avg : avg;
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      meta_q        <= 1'b0;
      sync_q        <= 1'b0;
      sync_prev_q   <= 1'b0;
      ox_q          <= '0;
      oy_q          <= '0;
      k_q           <= '0;
      sum_q         <= '0;
      addr_mem0_q   <= '0;
      addr_mem2_q   <= '0;
      data_mem2_q   <= '0;
      we_mem2_q     <= 1'b0;
      lenet_go_q    <= 1'b0;
      busy_q        <= 1'b0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      meta_q        <= lenet_signal;
      sync_q        <= meta_q;
      sync_prev_q   <= sync_q;
      ox_q          <= ox_d;
      oy_q          <= oy_d;
      k_q           <= k_d;
      sum_q         <= sum_d;
      addr_mem0_q   <= addr_mem0_d;
      addr_mem2_q   <= addr_mem2_d;
      data_mem2_q   <= data_mem2_d;
      we_mem2_q     <= (state_d == WRITE);
      lenet_go_q    <= (state_d == GO);
      busy_q        <= (state_d != IDLE);
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
    end
  end

  assign addr_mem0   = addr_mem0_q;
  assign addr_mem2   = addr_mem2_q;
  assign data_mem2   = data_mem2_q;
  assign we_mem2     = we_mem2_q;
  assign lenet_go    = lenet_go_q;
  assign busy        = busy_q;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
endmodule
